// File: rtl/bsg_print_stat_event_queue.sv
// Circular buffer of print_stat events (tag, timestamp, sequence number) drained
// by the host through a valid/yumi handshake, with drop accounting on overflow.
module bsg_print_stat_event_queue #(
  parameter int data_width_p     = 32,
  parameter int ctr_width_p      = 64,
  parameter int els_p            = 8,
  parameter int drop_ctr_width_p = 16,
  parameter int seq_width_p      = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         print_stat_v_i,
  input  logic [data_width_p-1:0]      print_stat_tag_i,
  input  logic [ctr_width_p-1:0]       global_ctr_i,
  output logic                         v_o,
  output logic [data_width_p-1:0]      tag_o,
  output logic [ctr_width_p-1:0]       ts_o,
  output logic [seq_width_p-1:0]       seq_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic [drop_ctr_width_p-1:0]  drop_count_o,
  output logic                         overflow_o
);

  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p+1);
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

  logic [data_width_p-1:0] tag_mem [els_p];
  logic [ctr_width_p-1:0]  ts_mem  [els_p];
  logic [seq_width_p-1:0]  seq_mem [els_p];

  logic [ptr_width_lp-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [ptr_width_lp-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [count_width_lp-1:0]   count_reg, count_next;
  logic [seq_width_p-1:0]      seq_reg, seq_next;
  logic [drop_ctr_width_p-1:0] drop_count_reg, drop_count_next;
  logic                        overflow_reg, overflow_next;

  logic event_v, full, deq, enq, drop;

  assign event_v = print_stat_v_i & en_i;
  assign full    = (count_reg == full_count_lp);
  assign v_o     = (count_reg != '0);
  assign deq     = yumi_i & v_o;
  // When full, only a same-cycle dequeue makes room for the incoming event.
  assign enq     = event_v & (full ? deq : 1'b1);
  assign drop    = event_v & full & ~deq;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      tag_mem[wr_ptr_reg] <= print_stat_tag_i;
      ts_mem[wr_ptr_reg]  <= global_ctr_i;
      seq_mem[wr_ptr_reg] <= seq_reg;
    end
  end

  assign tag_o        = v_o ? tag_mem[rd_ptr_reg] : '0;
  assign ts_o         = v_o ? ts_mem[rd_ptr_reg]  : '0;
  assign seq_o        = v_o ? seq_mem[rd_ptr_reg] : '0;
  assign count_o      = count_reg;
  assign drop_count_o = drop_count_reg;
  assign overflow_o   = overflow_reg;

  always_comb begin
    rd_ptr_next     = deq ? rd_ptr_reg + ptr_width_lp'(1) : rd_ptr_reg;
    wr_ptr_next     = enq ? wr_ptr_reg + ptr_width_lp'(1) : wr_ptr_reg;
    seq_next        = enq ? seq_reg + seq_width_p'(1) : seq_reg;
    count_next      = count_reg;
    drop_count_next = drop_count_reg;
    overflow_next   = overflow_reg;
    if (enq & ~deq) begin
      count_next = count_reg + count_width_lp'(1);
    end else if (~enq & deq) begin
      count_next = count_reg - count_width_lp'(1);
    end
    // A clear in the same cycle as a drop takes priority.
    if (clear_i) begin
      drop_count_next = '0;
      overflow_next   = 1'b0;
    end else if (drop) begin
      overflow_next = 1'b1;
      if (drop_count_reg != '1) begin
        drop_count_next = drop_count_reg + drop_ctr_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      seq_reg        <= '0;
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      seq_reg        <= seq_next;
      drop_count_reg <= drop_count_next;
      overflow_reg   <= overflow_next;
    end
  end

endmodule

// File: tb/tb_bsg_print_stat_event_queue.sv
// Bench for bsg_print_stat_event_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bsg_print_stat_event_queue;

  localparam int ELS   = 8;
  localparam int DW    = 4;
  localparam int DMAX  = (1 << DW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          print_stat_v_i = 1'b0;
  logic [31:0]   print_stat_tag_i = '0;
  logic [63:0]   global_ctr_i = '0;
  logic          v_o;
  logic [31:0]   tag_o;
  logic [63:0]   ts_o;
  logic [15:0]   seq_o;
  logic          yumi_i = 1'b0;
  logic [3:0]    count_o;
  logic [DW-1:0] drop_count_o;
  logic          overflow_o;

  bsg_print_stat_event_queue #(
    .data_width_p(32), .ctr_width_p(64), .els_p(ELS),
    .drop_ctr_width_p(DW), .seq_width_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i),
    .print_stat_v_i(print_stat_v_i), .print_stat_tag_i(print_stat_tag_i),
    .global_ctr_i(global_ctr_i), .v_o(v_o), .tag_o(tag_o), .ts_o(ts_o),
    .seq_o(seq_o), .yumi_i(yumi_i), .count_o(count_o),
    .drop_count_o(drop_count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] tag;
    logic [63:0] ts;
    logic [15:0] seq;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_seq = '0;
  int          m_drop = 0;
  logic        m_ovf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of events, updated from the inputs seen at each edge.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q.delete();
      m_seq  = '0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      bit was_full, took;
      was_full = (q.size() == ELS);
      took     = yumi_i && (q.size() != 0);
      chk("yumi_protocol", {63'd0, yumi_i && (q.size() == 0)}, 64'd0);
      if (took) begin
        $display("deq tag=%0h ts=%0d seq=%0d", q[0].tag, q[0].ts, q[0].seq);
        void'(q.pop_front());
      end
      if (print_stat_v_i && en_i) begin
        if (was_full && !took) begin
          if (m_drop != DMAX) m_drop++;
          m_ovf = 1'b1;
        end else begin
          q.push_back('{tag: print_stat_tag_i, ts: global_ctr_i, seq: m_seq});
          m_seq = m_seq + 16'd1;
        end
      end
      if (clear_i) begin
        m_drop = 0;
        m_ovf  = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      chk("v_o", {63'd0, v_o}, {63'd0, q.size() != 0});
      chk("count_o", {60'd0, count_o}, 64'(q.size()));
      if (q.size() != 0) begin
        chk("tag_o", {32'd0, tag_o}, {32'd0, q[0].tag});
        chk("ts_o", ts_o, q[0].ts);
        chk("seq_o", {48'd0, seq_o}, {48'd0, q[0].seq});
      end else begin
        chk("tag_o_masked", {32'd0, tag_o}, 64'd0);
        chk("ts_o_masked", ts_o, 64'd0);
        chk("seq_o_masked", {48'd0, seq_o}, 64'd0);
      end
      chk("drop_count_o", {60'd0, drop_count_o}, 64'(m_drop));
      chk("overflow_o", {63'd0, overflow_o}, {63'd0, m_ovf});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] tag, input logic [63:0] ctr,
                     input logic y, input logic en, input logic clr);
    print_stat_v_i   = v;
    print_stat_tag_i = tag;
    global_ctr_i     = ctr;
    yumi_i           = y;
    en_i             = en;
    clear_i          = clr;
    @(negedge clk_i);
  endtask

  initial begin
    int sent;
    int guard;
    logic v, y;

    repeat (2) @(negedge clk_i);
    chk("rst_v_o", {63'd0, v_o}, 64'd0);
    chk("rst_count_o", {60'd0, count_o}, 64'd0);
    chk("rst_tag_o", {32'd0, tag_o}, 64'd0);
    chk("rst_drop", {60'd0, drop_count_o}, 64'd0);
    chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
    reset_i = 1'b0;

    // 1: single event, visible next cycle
    cyc(1, 32'h1234, 64'd100, 0, 1, 0);
    chk("t1_v_o", {63'd0, v_o}, 64'd1);
    chk("t1_tag", {32'd0, tag_o}, 64'h1234);
    chk("t1_ts", ts_o, 64'd100);
    chk("t1_seq", {48'd0, seq_o}, 64'd0);
    chk("t1_count", {60'd0, count_o}, 64'd1);

    reset_i = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;

    // 2: fill then overflow by two
    for (int i = 0; i < ELS; i++) cyc(1, 32'hA0 + i, 64'(200 + i), 0, 1, 0);
    chk("t2_count_full", {60'd0, count_o}, 64'd8);
    for (int i = 0; i < 2; i++) cyc(1, 32'hB0 + i, 64'(210 + i), 0, 1, 0);
    chk("t2_drop", {60'd0, drop_count_o}, 64'd2);
    chk("t2_ovf", {63'd0, overflow_o}, 64'd1);
    chk("t2_head_seq", {48'd0, seq_o}, 64'd0);
    chk("t2_head_tag", {32'd0, tag_o}, 64'hA0);

    // 3: full with simultaneous event and yumi
    cyc(1, 32'hBEEF, 64'd300, 1, 1, 0);
    chk("t3_head_seq", {48'd0, seq_o}, 64'd1);
    chk("t3_head_ts", ts_o, 64'd201);
    chk("t3_count", {60'd0, count_o}, 64'd8);
    chk("t3_drop", {60'd0, drop_count_o}, 64'd2);

    // 4: disabled events, clear, saturation, clear-beats-drop, dequeue while disabled
    for (int i = 0; i < 3; i++) cyc(1, 32'h55, 64'(310 + i), 0, 0, 0);
    chk("t4_count", {60'd0, count_o}, 64'd8);
    chk("t4_drop", {60'd0, drop_count_o}, 64'd2);
    cyc(0, 0, 64'd320, 0, 1, 1);
    chk("t4_clr_drop", {60'd0, drop_count_o}, 64'd0);
    chk("t4_clr_ovf", {63'd0, overflow_o}, 64'd0);
    for (int i = 0; i < DMAX + 2; i++) cyc(1, 32'h66, 64'(330 + i), 0, 1, 0);
    chk("t4_sat_drop", {60'd0, drop_count_o}, 64'(DMAX));
    chk("t4_sat_ovf", {63'd0, overflow_o}, 64'd1);
    cyc(1, 32'h67, 64'd360, 0, 1, 1);
    chk("t4_clrwin_drop", {60'd0, drop_count_o}, 64'd0);
    chk("t4_clrwin_ovf", {63'd0, overflow_o}, 64'd0);
    cyc(0, 0, 64'd361, 1, 0, 0);
    chk("t4_deq_disabled", {60'd0, count_o}, 64'd7);
    chk("t4_head_seq", {48'd0, seq_o}, 64'd2);

    // 5: drain, then 20 events with random yumi across pointer wrap
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      cyc(0, 0, 64'(400 + guard), 1, 1, 0);
      guard++;
    end
    chk("t5_drained", 64'(q.size()), 64'd0);
    sent = 0;
    guard = 0;
    while ((sent < 20 || q.size() != 0) && guard < 400) begin
      v = (sent < 20) && ($urandom_range(0, 1) == 1);
      y = (q.size() != 0) && ($urandom_range(0, 2) != 0);
      cyc(v, $urandom, 64'(1000 + 3 * guard), y, 1, 0);
      if (v) sent++;
      guard++;
    end
    chk("t5_done", {63'd0, (sent == 20) && (q.size() == 0)}, 64'd1);

    // 6: async reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, 32'hC0 + i, 64'(2000 + i), 0, 1, 0);
    chk("t6_count5", {60'd0, count_o}, 64'd5);
    print_stat_v_i = 1'b0;
    yumi_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("t6_async_v", {63'd0, v_o}, 64'd0);
    chk("t6_async_count", {60'd0, count_o}, 64'd0);
    chk("t6_async_tag", {32'd0, tag_o}, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    cyc(1, 32'h77, 64'd3000, 0, 1, 0);
    chk("t6_seq0", {48'd0, seq_o}, 64'd0);
    chk("t6_tag", {32'd0, tag_o}, 64'h77);
    chk("t6_count", {60'd0, count_o}, 64'd1);
    cyc(0, 0, 64'd3001, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
